// File: rtl/mem_access_stage.sv
// MEM stage: registers execute results, resolves branches and performs loads/stores
// on a word-addressed data memory with a programmable access latency.
module mem_access_stage #(
  parameter int ADDR_W  = 6,
  parameter int MEM_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] ALU_Result_in,
  input  logic        Zero_in,
  input  logic [15:0] adder_in,
  input  logic [15:0] regfile_read_data_2_in,
  input  logic [2:0]  write_reg_in,
  input  logic        Branch_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  output logic        stall,
  output logic        PCSrc,
  output logic [15:0] branch_target_out,
  output logic        valid_out,
  output logic [15:0] mem_read_data_out,
  output logic [15:0] alu_result_out,
  output logic [2:0]  write_reg_out,
  output logic        RegWrite_out,
  output logic        MemtoReg_out
);

  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam bit FAST  = (MEM_LAT == 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       mem [2**ADDR_W];

  logic [ADDR_W-1:0] addr_p1;
  logic [15:0]       wdata_p1;
  logic [15:0]       alu_p1;
  logic [2:0]        wreg_p1;
  logic              rd_p1, wr_p1, regwrite_p1, memtoreg_p1;

  logic              accept, is_mem, finish;
  logic [ADDR_W-1:0] addr_in;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;

  assign addr_in           = ALU_Result_in[ADDR_W-1:0];
  assign accept            = (state == IDLE) && valid_in;
  assign is_mem            = MemRead_in | MemWrite_in;
  assign finish            = (state == BUSY) && (cnt == CNT_W'(1));
  assign PCSrc             = valid_in & Branch_in & Zero_in & ~stall;
  assign branch_target_out = adder_in;

  // With single-cycle latency the write lands on the accept edge; otherwise on the completing edge.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_p1;
    mem_wdata = wdata_p1;
    if (FAST) begin
      mem_we    = accept && MemWrite_in && !rst;
      mem_waddr = addr_in;
      mem_wdata = regfile_read_data_2_in;
    end else begin
      mem_we    = finish && wr_p1 && !rst;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Stage p1: operands of a multi-cycle memory op held while BUSY
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1     <= addr_in;
      wdata_p1    <= regfile_read_data_2_in;
      alu_p1      <= ALU_Result_in;
      wreg_p1     <= write_reg_in;
      rd_p1       <= MemRead_in;
      wr_p1       <= MemWrite_in;
      regwrite_p1 <= RegWrite_in;
      memtoreg_p1 <= MemtoReg_in;
    end
  end

  // Stage p2: MEM/WB outputs and access sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      stall             <= 1'b0;
      valid_out         <= 1'b0;
      mem_read_data_out <= '0;
      alu_result_out    <= '0;
      write_reg_out     <= '0;
      RegWrite_out      <= 1'b0;
      MemtoReg_out      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in && is_mem && !FAST) begin
            state        <= BUSY;
            cnt          <= CNT_W'(MEM_LAT - 1);
            stall        <= 1'b1;
            valid_out    <= 1'b0;
            RegWrite_out <= 1'b0;
          end else if (valid_in) begin
            valid_out         <= 1'b1;
            alu_result_out    <= ALU_Result_in;
            write_reg_out     <= write_reg_in;
            RegWrite_out      <= RegWrite_in;
            MemtoReg_out      <= MemtoReg_in;
            mem_read_data_out <= (MemRead_in && !MemWrite_in) ? mem[addr_in] : 16'h0000;
          end else begin
            valid_out    <= 1'b0;
            RegWrite_out <= 1'b0;
          end
        end
        BUSY: begin
          if (finish) begin
            state             <= IDLE;
            stall             <= 1'b0;
            valid_out         <= 1'b1;
            alu_result_out    <= alu_p1;
            write_reg_out     <= wreg_p1;
            RegWrite_out      <= regwrite_p1;
            MemtoReg_out      <= memtoreg_p1;
            mem_read_data_out <= (rd_p1 && !wr_p1) ? mem[addr_p1] : 16'h0000;
          end else begin
            cnt          <= cnt - CNT_W'(1);
            valid_out    <= 1'b0;
            RegWrite_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
